// File: rtl/nes_pad_sequencer.sv
// NES controller poller: drives shared latch/serial-clock lines and returns one button word per controller.
// Optional free-running auto poll enabled by defining NES_AUTO_POLL_EN.
module nes_pad_sequencer #(
    parameter int unsigned CLK_DIV     = 6,
    parameter int unsigned NUM_BITS    = 8,
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned POLL_PERIOD = 16667
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic                         busy,
    output logic                         nes_latch,
    output logic                         nes_clk,
    input  logic [NUM_CH-1:0]            nes_data,
    output logic [NUM_CH*NUM_BITS-1:0]   buttons,
    output logic                         valid
);

    localparam int unsigned PH_W   = $clog2(2 * CLK_DIV);
    localparam int unsigned BIT_W  = $clog2(NUM_BITS);
    localparam int unsigned WORD_W = NUM_CH * NUM_BITS;

    generate
        if (CLK_DIV < 3 || NUM_BITS < 2 || NUM_CH < 1 || POLL_PERIOD < 1) begin : g_bad_params
            $error("nes_pad_sequencer: illegal parameter value");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;

    state_t             state, state_next;
    logic [PH_W-1:0]    phase, phase_next;
    logic [BIT_W-1:0]   bit_idx, bit_idx_next;
    logic [WORD_W-1:0]  shift, shift_next;
    logic [NUM_CH-1:0]  sync1, sync2;
    logic               start_eff;

`ifdef NES_AUTO_POLL_EN
    localparam int unsigned PC_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    logic [PC_W-1:0] poll_cnt;
    logic            poll_req;

    // Free-running period counter; a request that lands while busy is simply lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            poll_cnt <= '0;
        else if (poll_req)
            poll_cnt <= '0;
        else
            poll_cnt <= poll_cnt + PC_W'(1);
    end

    assign poll_req  = (poll_cnt == PC_W'(POLL_PERIOD - 1));
    assign start_eff = start | poll_req;
`else
    assign start_eff = start;
`endif

    // Pad data is asynchronous to clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= nes_data;
            sync2 <= sync1;
        end
    end

    always_comb begin
        state_next   = state;
        phase_next   = phase;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        case (state)
            IDLE: begin
                phase_next = '0;
                if (start_eff) begin
                    state_next   = LATCH;
                    bit_idx_next = '0;
                end
            end
            LATCH: begin
                if (phase == PH_W'(2 * CLK_DIV - 1)) begin
                    phase_next = '0;
                    state_next = LOW;
                end else begin
                    phase_next = phase + PH_W'(1);
                end
            end
            LOW: begin
                if (phase == PH_W'(CLK_DIV - 1)) begin
                    phase_next = '0;
                    for (int c = 0; c < NUM_CH; c++)
                        shift_next[c * NUM_BITS + int'(bit_idx)] = sync2[c];
                    state_next = (bit_idx == BIT_W'(NUM_BITS - 1)) ? DONE : HIGH;
                end else begin
                    phase_next = phase + PH_W'(1);
                end
            end
            HIGH: begin
                if (phase == PH_W'(CLK_DIV - 1)) begin
                    phase_next   = '0;
                    bit_idx_next = bit_idx + BIT_W'(1);
                    state_next   = LOW;
                end else begin
                    phase_next = phase + PH_W'(1);
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            busy      <= 1'b0;
            nes_latch <= 1'b0;
            nes_clk   <= 1'b0;
            valid     <= 1'b0;
            buttons   <= '0;
        end else begin
            state     <= state_next;
            phase     <= phase_next;
            bit_idx   <= bit_idx_next;
            shift     <= shift_next;
            busy      <= (state_next != IDLE);
            nes_latch <= (state_next == LATCH);
            nes_clk   <= (state_next == HIGH);
            valid     <= (state_next == DONE);
            if (state == LOW && state_next == DONE)
                buttons <= ~shift_next;
        end
    end

endmodule
